cipher_interface_ctrl: RTL and testbench
========================================

// Module: cipher_interface_ctrl
// PURPOSE
// - Sequencing controller for the stream-cipher datapath: accepts user key/data byte commands,
//   starts the encryption block and waits for the output holder to report READY.
// - Presents the held result until the user acknowledges it, then returns to IDLE,
//   which releases the output holder to EMPTY.
// - Sole driver of interface_state consumed by the output holder and the output mux.
// PARAMETERS
// - KEY_BYTES     4    key bytes per key load; >=2
// - TIMEOUT_CYC   255  max cycles in WAIT_RESULT before ERROR; >=1
// PORTS
// - clk            in   1   clock, all logic on posedge
// - rst            in   1   asynchronous reset, active-high
// - cmd_valid      in   1   user command strobe, one command per cycle high
// - cmd_is_key     in   1   1 = key byte, 0 = data byte; sampled with cmd_valid
// - rd_ack         in   1   user has read data_out; only honoured in PRESENT
// - err_clr        in   1   clears ERROR; only honoured in ERROR
// - holder_ready   in   1   output holder state, 1 = READY
// - cmd_ready      out  1   1 in IDLE and KEY_LOAD only
// - key_we         out  1   one-cycle key byte write strobe to encryption block
// - key_idx        out  $clog2(KEY_BYTES)  key byte index for key_we
// - enc_start      out  1   one-cycle start strobe to encryption block
// - interface_state out 3   IDLE=0 KEY_LOAD=1 WAIT_RESULT=2 PRESENT=3 ERROR=4
// - key_loaded     out  1   full key written since reset
// - out_valid      out  1   1 exactly in PRESENT
// - cmd_reject     out  1   one-cycle pulse: command dropped
// - timeout_err    out  1   1 exactly in ERROR
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, key_idx=0, key_loaded=0, all strobes 0, cmd_ready=1.
// - All outputs registered or decoded from registered state; strobes are 1 cycle after accept.
// - IDLE: cmd_valid&cmd_is_key -> key_we, key_idx=0 written, idx->1, go KEY_LOAD.
//   cmd_valid&!cmd_is_key&key_loaded -> enc_start, timer=0, go WAIT_RESULT.
//   cmd_valid&!cmd_is_key&!key_loaded -> cmd_reject, stay IDLE.
// - KEY_LOAD: cmd_valid&cmd_is_key -> key_we at key_idx, idx++; on byte KEY_BYTES-1:
//   idx wraps to 0, key_loaded=1, go IDLE. Data cmd in KEY_LOAD -> cmd_reject, stay.
//   A new key load restarts at idx 0; key_loaded stays 1 (old key cleared only by reset).
// - WAIT_RESULT: holder_ready=1 -> PRESENT (same cycle as timer check; ready wins).
//   else timer++; timer reaching TIMEOUT_CYC -> ERROR. cmd_valid here -> cmd_reject.
// - PRESENT: out_valid=1; rd_ack -> IDLE. cmd_valid here -> cmd_reject (rd_ack still honoured).
// - ERROR: timeout_err=1; err_clr -> IDLE. cmd_valid -> cmd_reject.
// - Holder returns EMPTY one cycle after interface_state=IDLE; controller never re-enters
//   WAIT_RESULT from PRESENT directly, so a stale READY is never taken for a new result.
// - Timer width $clog2(TIMEOUT_CYC+1); saturates, never wraps.
// - rd_ack/err_clr outside their state: ignored, no reject pulse.
// TESTING
// - Reset, 4 key cmds on consecutive cycles -> key_we x4 idx 0,1,2,3; key_loaded=1; state IDLE.
// - Data cmd before key -> cmd_reject 1 cycle, no enc_start, state stays 0.
// - Key loaded, data cmd; holder_ready after 5 cyc -> enc_start 1 cyc, state 2->3, out_valid=1;
//   rd_ack -> state 0, out_valid=0.
// - TIMEOUT_CYC=8, holder_ready never -> state 4 after 8 cyc in WAIT_RESULT; err_clr -> 0.
// - holder_ready on exact timeout cycle -> PRESENT, not ERROR.
// - rst asserted mid KEY_LOAD (idx=2) -> immediate IDLE, idx=0, key_loaded=0, strobes 0.

Source files
------------

// File: rtl/cipher_interface_ctrl.sv
// Sequencing controller for the stream-cipher datapath: key/data byte commands,
// encryption start, result wait with timeout, result presentation and error recovery.
module cipher_interface_ctrl #(
  parameter int KEY_BYTES   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  input  logic                         cmd_is_key,
  input  logic                         rd_ack,
  input  logic                         err_clr,
  input  logic                         holder_ready,
  output logic                         cmd_ready,
  output logic                         key_we,
  output logic [$clog2(KEY_BYTES)-1:0] key_idx,
  output logic                         enc_start,
  output logic [2:0]                   interface_state,
  output logic                         key_loaded,
  output logic                         out_valid,
  output logic                         cmd_reject,
  output logic                         timeout_err
);

  localparam int IW = $clog2(KEY_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(KEY_BYTES - 1);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_KEY_LOAD    = 3'd1,
    S_WAIT_RESULT = 3'd2,
    S_PRESENT     = 3'd3,
    S_ERROR       = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;          // next key byte index to be written
  logic [IW-1:0] key_idx_q, key_idx_d;  // index that accompanies key_we
  logic          key_loaded_q, key_loaded_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] timer_inc;
  logic          key_we_q, key_we_d;
  logic          enc_start_q, enc_start_d;
  logic          cmd_reject_q, cmd_reject_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      key_idx_q    <= '0;
      key_loaded_q <= 1'b0;
      timer_q      <= '0;
      key_we_q     <= 1'b0;
      enc_start_q  <= 1'b0;
      cmd_reject_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_idx_q    <= key_idx_d;
      key_loaded_q <= key_loaded_d;
      timer_q      <= timer_d;
      key_we_q     <= key_we_d;
      enc_start_q  <= enc_start_d;
      cmd_reject_q <= cmd_reject_d;
    end
  end

  // Saturating increment: the timer may never wrap back into the wait window.
  assign timer_inc = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_idx_d    = key_idx_q;
    key_loaded_d = key_loaded_q;
    timer_d      = timer_q;
    key_we_d     = 1'b0;
    enc_start_d  = 1'b0;
    cmd_reject_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_is_key) begin
            key_we_d  = 1'b1;
            key_idx_d = '0;
            cnt_d     = IW'(1);
            state_d   = S_KEY_LOAD;
          end else if (key_loaded_q) begin
            enc_start_d = 1'b1;
            timer_d     = '0;
            state_d     = S_WAIT_RESULT;
          end else begin
            cmd_reject_d = 1'b1;
          end
        end
      end
      S_KEY_LOAD: begin
        if (cmd_valid) begin
          if (cmd_is_key) begin
            key_we_d  = 1'b1;
            key_idx_d = cnt_q;
            if (cnt_q == LAST_IDX) begin
              cnt_d        = '0;
              key_loaded_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              cnt_d = cnt_q + IW'(1);
            end
          end else begin
            cmd_reject_d = 1'b1;
          end
        end
      end
      S_WAIT_RESULT: begin
        cmd_reject_d = cmd_valid;
        // A result arriving on the timeout cycle still wins over the error.
        if (holder_ready) begin
          state_d = S_PRESENT;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TMAX) state_d = S_ERROR;
        end
      end
      S_PRESENT: begin
        cmd_reject_d = cmd_valid;
        if (rd_ack) state_d = S_IDLE;
      end
      S_ERROR: begin
        cmd_reject_d = cmd_valid;
        if (err_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready       = (state_q == S_IDLE) || (state_q == S_KEY_LOAD);
  assign key_we          = key_we_q;
  assign key_idx         = key_idx_q;
  assign enc_start       = enc_start_q;
  assign interface_state = state_q;
  assign key_loaded      = key_loaded_q;
  assign out_valid       = (state_q == S_PRESENT);
  assign cmd_reject      = cmd_reject_q;
  assign timeout_err     = (state_q == S_ERROR);

endmodule

// File: tb/tb_cipher_interface_ctrl.sv
// Bench for cipher_interface_ctrl: directed vector table, hand-written reset corner,
// then randomized traffic checked against a behavioural model of the controller.
module tb_cipher_interface_ctrl;

  localparam int KEY_BYTES   = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int IW          = $clog2(KEY_BYTES);

  localparam int P_IDLE = 0, P_KEY = 1, P_WAIT = 2, P_PRESENT = 3, P_ERROR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_is_key, rd_ack, err_clr, holder_ready;
  logic          cmd_ready, key_we, enc_start, key_loaded, out_valid, cmd_reject, timeout_err;
  logic [IW-1:0] key_idx;
  logic [2:0]    interface_state;

  int n_checks = 0;
  int n_fail   = 0;

  cipher_interface_ctrl #(.KEY_BYTES(KEY_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_is_key(cmd_is_key), .rd_ack(rd_ack),
    .err_clr(err_clr), .holder_ready(holder_ready),
    .cmd_ready(cmd_ready), .key_we(key_we), .key_idx(key_idx),
    .enc_start(enc_start), .interface_state(interface_state),
    .key_loaded(key_loaded), .out_valid(out_valid),
    .cmd_reject(cmd_reject), .timeout_err(timeout_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_phase, m_bytes, m_waited, m_idx;
  bit m_loaded, m_we, m_enc, m_rej;

  task automatic model_reset();
    m_phase = P_IDLE; m_bytes = 0; m_waited = 0; m_idx = 0;
    m_loaded = 0; m_we = 0; m_enc = 0; m_rej = 0;
  endtask

  // Outcome of one clock edge, decided from what the user and holder did this cycle.
  task automatic model_step(input bit cv, input bit key, input bit ack, input bit clr,
                            input bit rdy);
    m_we = 0; m_enc = 0; m_rej = 0;
    if (m_phase == P_IDLE || m_phase == P_KEY) begin
      if (cv && key) begin
        if (m_phase == P_IDLE) m_bytes = 0;
        m_we = 1;
        m_idx = m_bytes;
        m_bytes++;
        m_phase = P_KEY;
        if (m_bytes == KEY_BYTES) begin
          m_loaded = 1;
          m_bytes  = 0;
          m_phase  = P_IDLE;
        end
      end else if (cv && m_phase == P_IDLE && m_loaded) begin
        m_enc = 1;
        m_waited = 0;
        m_phase = P_WAIT;
      end else if (cv) begin
        m_rej = 1;
      end
    end else begin
      m_rej = cv;
      if (m_phase == P_WAIT) begin
        if (rdy) m_phase = P_PRESENT;
        else begin
          m_waited++;
          if (m_waited >= TIMEOUT_CYC) m_phase = P_ERROR;
        end
      end else if (m_phase == P_PRESENT && ack) m_phase = P_IDLE;
      else if (m_phase == P_ERROR && clr) m_phase = P_IDLE;
    end
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic drive_cycle(input bit cv, input bit key, input bit ack, input bit clr,
                             input bit rdy);
    @(negedge clk);
    cmd_valid = cv; cmd_is_key = key; rd_ack = ack; err_clr = clr; holder_ready = rdy;
    @(posedge clk);
    model_step(cv, key, ack, clr, rdy);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input bit we, input int idx,
                           input bit enc, input bit rej, input bit ld);
    check({tag, " state"}, int'(interface_state), st);
    check({tag, " key_we"}, int'(key_we), int'(we));
    if (we) check({tag, " key_idx"}, int'(key_idx), idx);
    check({tag, " enc_start"}, int'(enc_start), int'(enc));
    check({tag, " cmd_reject"}, int'(cmd_reject), int'(rej));
    check({tag, " key_loaded"}, int'(key_loaded), int'(ld));
    check({tag, " cmd_ready"}, int'(cmd_ready), int'(st == P_IDLE || st == P_KEY));
    check({tag, " out_valid"}, int'(out_valid), int'(st == P_PRESENT));
    check({tag, " timeout_err"}, int'(timeout_err), int'(st == P_ERROR));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit cv, key, ack, clr, rdy;
    int st;
    bit we;
    int idx;
    bit enc, rej, ld;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit cv, input bit key, input bit ack, input bit clr, input bit rdy,
                     input int st, input bit we, input int idx, input bit enc, input bit rej,
                     input bit ld);
    vec_t v;
    v.cv = cv; v.key = key; v.ack = ack; v.clr = clr; v.rdy = rdy;
    v.st = st; v.we = we; v.idx = idx; v.enc = enc; v.rej = rej; v.ld = ld;
    tbl.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    drive_cycle(v.cv, v.key, v.ack, v.clr, v.rdy);
    check_all(tag, v.st, v.we, v.idx, v.enc, v.rej, v.ld);
  endtask

  initial begin
    //   cv key ack clr rdy   st we idx enc rej ld
    add(1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);   // data before any key: rejected
    add(1, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,   1, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0,   1, 1, 2, 0, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0);   // data mid key load: rejected
    add(1, 1, 0, 0, 0,   0, 1, 3, 0, 0, 1);   // last byte -> IDLE, key loaded
    add(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1);   // READY in IDLE ignored
    add(1, 0, 0, 0, 0,   2, 0, 0, 1, 0, 1);   // start encryption
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1,   3, 0, 0, 0, 0, 1);   // result after 5 cycles
    add(1, 1, 0, 0, 0,   3, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 0,   0, 0, 0, 0, 1, 1);   // ack honoured alongside reject
    add(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1);   // err_clr outside ERROR ignored
    add(1, 0, 0, 0, 0,   2, 0, 0, 1, 0, 1);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) add(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 1);   // timeout
    add(0, 0, 1, 0, 0,   4, 0, 0, 0, 0, 1);   // rd_ack in ERROR ignored
    add(1, 0, 0, 0, 0,   4, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0,   2, 0, 0, 1, 0, 1);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) add(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1,   3, 0, 0, 0, 0, 1);   // READY on exact timeout cycle wins
    add(0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0,   1, 1, 0, 0, 0, 1);   // reload restarts at 0, loaded stays
    add(1, 1, 0, 0, 0,   1, 1, 1, 0, 0, 1);
    add(1, 1, 0, 0, 0,   1, 1, 2, 0, 0, 1);
  end

  // ---------------- main sequence / scoreboard ----------------
  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_is_key = 0; rd_ack = 0; err_clr = 0; holder_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", P_IDLE, 0, 0, 0, 0, 0);
    check("reset key_idx", int'(key_idx), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a key load (next index would be 3).
    cmd_valid = 0; cmd_is_key = 0; rd_ack = 0; err_clr = 0; holder_ready = 0;
    #2 rst = 1'b1;
    #1;
    check_all("midrst", P_IDLE, 0, 0, 0, 0, 0);
    check("midrst key_idx", int'(key_idx), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(1, 0, 0, 0, 0);
    check_all("postrst data", P_IDLE, 0, 0, 0, 1, 0);
    drive_cycle(1, 1, 0, 0, 0);
    check_all("postrst key", P_KEY, 1, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit cv, key, ack, clr, rdy;
      cv  = ($urandom_range(0, 99) < 45);
      key = ($urandom_range(0, 99) < 55);
      ack = ($urandom_range(0, 99) < 30);
      clr = ($urandom_range(0, 99) < 30);
      rdy = ($urandom_range(0, 99) < 9);
      drive_cycle(cv, key, ack, clr, rdy);
      check_all($sformatf("rand%0d", n), m_phase, m_we, m_idx, m_enc, m_rej, m_loaded);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
